// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM states, default baud
//               divisor and CRC polynomial, and the byte-wise CRC-8 helper
//               also used by the transmitter checksum path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int         c_default_baud_div = 418;
  localparam logic [7:0] c_default_poly     = 8'h07;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Non-reflected CRC-8, MSB first: fold the byte in, then 8 shift/XOR steps.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] byte_in,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ poly;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for an asynchronous input. Both flops
//               reset to 1 so an idle-high line reads idle out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  // Two-stage capture of the asynchronous input, reset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      o_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver. Deserialises frames from the rx pin,
//               strobes each good byte out, flags bad stop bits and keeps a
//               running CRC-8 over all good bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int         BAUD_DIV = c_default_baud_div,
  parameter logic [7:0] POLY     = c_default_poly
) (
  input  logic       a,
  input  logic       b,
  input  logic       rx,
  input  logic       crc_clr,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic [7:0] crc,
  output logic       crc_zero,
  output logic       busy
);

  localparam int            c_cnt_w     = $clog2(BAUD_DIV + 1);
  // The counter is loaded one below the wait length because the sample is
  // taken in the cycle where the counter reads zero.
  localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(BAUD_DIV / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_load = c_cnt_w'(BAUD_DIV - 1);

  rx_state_t            r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_bitcnt;
  logic [7:0]           r_shift;
  logic                 r_rxs_d;
  logic                 w_rxs;
  logic                 w_fall;
  logic [7:0]           w_crc_base;

  uart_rx_sync u_sync (
    .clk (a),
    .rst (b),
    .i_d (rx),
    .o_q (w_rxs)
  );

  assign w_fall     = r_rxs_d & ~w_rxs;
  // A clear arriving with a good byte wins, but the byte is still folded in.
  assign w_crc_base = crc_clr ? 8'h00 : crc;
  assign crc_zero   = (crc == 8'h00);

  // One-cycle delayed copy of the synchronised line for edge detection.
  always_ff @(posedge a or posedge b) begin
    if (b) r_rxs_d <= 1'b1;
    else   r_rxs_d <= w_rxs;
  end

  // Frame FSM with bit timing, shift register, registered outputs and CRC.
  always_ff @(posedge a or posedge b) begin
    if (b) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      crc        <= 8'h00;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (crc_clr) crc <= 8'h00;

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state  <= START;
            r_cnt    <= c_half_load;
            r_bitcnt <= 3'd0;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (r_cnt == '0) begin
            if (!w_rxs) begin
              r_state <= DATA;
              r_cnt   <= c_full_load;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_rxs, r_shift[7:1]};
            r_cnt   <= c_full_load;
            if (r_bitcnt == 3'd7) r_state <= STOP;
            else                  r_bitcnt <= r_bitcnt + 3'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        STOP: begin
          if (r_cnt == '0) begin
            if (w_rxs) begin
              data       <= r_shift;
              data_valid <= 1'b1;
              crc        <= crc8_byte(w_crc_base, r_shift, POLY);
              r_state    <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              r_state   <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        BREAK: begin
          // Wait for the line to recover so a held-low line is one event.
          if (w_rxs) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver with a bit-serial
//               CRC-8 reference and directed plus random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int BD = 16;

  logic       a = 1'b0;
  logic       b = 1'b1;
  logic       rx = 1'b1;
  logic       crc_clr = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic [7:0] crc;
  logic       crc_zero;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_ferr  = 0;

  logic [7:0] m_crc;
  logic [7:0] m_data;

  uart_receiver #(.BAUD_DIV(BD), .POLY(8'h07)) dut (
    .a          (a),
    .b          (b),
    .rx         (rx),
    .crc_clr    (crc_clr),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .crc        (crc),
    .crc_zero   (crc_zero),
    .busy       (busy)
  );

  always #5 a = ~a;

  // Pulse counters, sampled away from the active edge.
  always @(negedge a) begin
    if (data_valid) n_valid++;
    if (frame_err)  n_ferr++;
  end

  // Reference CRC: polynomial long division one message bit at a time.
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame LSB first; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stopv);
    rx = 1'b0;
    repeat (BD) @(negedge a);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BD) @(negedge a);
    end
    rx = stopv;
    repeat (BD) @(negedge a);
  endtask

  task automatic send_good(input logic [7:0] d, input string tag);
    int v0;
    v0 = n_valid;
    send_frame(d, 1'b1);
    m_crc  = ref_crc(m_crc, d);
    m_data = d;
    chk({tag, "_pulses"}, n_valid - v0, 1);
    chk({tag, "_data"},   data, m_data);
    chk({tag, "_crc"},    crc, m_crc);
    chk({tag, "_zero"},   crc_zero, (m_crc == 8'h00));
  endtask

  initial begin
    int v0;
    int f0;
    logic [7:0] str [9];
    logic [7:0] rb;

    m_crc  = 8'h00;
    m_data = 8'h00;

    // Reset state
    repeat (3) @(negedge a);
    chk("rst_data",  data, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_ferr",  frame_err, 1'b0);
    chk("rst_crc",   crc, 8'h00);
    chk("rst_zero",  crc_zero, 1'b1);
    chk("rst_busy",  busy, 1'b0);
    b = 1'b0;
    repeat (5) @(negedge a);

    // Single byte
    send_good(8'hA5, "a5");
    chk("a5_ferr", n_ferr, 0);
    chk("a5_idle_busy", busy, 1'b0);

    // Back-to-back bytes whose CRC cancels
    crc_clr = 1'b1; @(negedge a); crc_clr = 1'b0;
    m_crc = 8'h00;
    chk("clr1_crc", crc, 8'h00);
    send_good(8'h01, "b01");
    chk("b01_abs", crc, 8'h07);
    send_good(8'h07, "b07");
    chk("b07_abs", crc, 8'h00);

    // Check string
    str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    v0 = n_valid;
    for (int i = 0; i < 9; i++) send_good(str[i], "str");
    chk("str_count", n_valid - v0, 9);
    chk("str_crc_abs", crc, 8'hF4);
    crc_clr = 1'b1; @(negedge a); crc_clr = 1'b0;
    m_crc = 8'h00;
    chk("clr2_crc", crc, 8'h00);
    chk("clr2_zero", crc_zero, 1'b1);

    // Give a nonzero CRC before the framing error so "unchanged" means something
    send_good(8'h9E, "pre_err");

    // Framing error followed by a held-low line
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    repeat (3 * BD) @(negedge a);
    chk("ferr_pulses", n_ferr - f0, 1);
    chk("ferr_valid",  n_valid - v0, 0);
    chk("ferr_data",   data, m_data);
    chk("ferr_crc",    crc, m_crc);
    chk("ferr_busy_low", busy, 1'b1);
    rx = 1'b1;
    repeat (6) @(negedge a);
    chk("ferr_busy_rel", busy, 1'b0);
    repeat (12 * BD) @(negedge a);
    chk("ferr_no_new_f", n_ferr - f0, 1);
    chk("ferr_no_new_v", n_valid - v0, 0);

    // Short glitch on an idle line
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(negedge a);
    rx = 1'b1;
    chk("gl_busy_hi", busy, 1'b1);
    repeat (2 * BD) @(negedge a);
    chk("gl_busy_lo", busy, 1'b0);
    chk("gl_valid", n_valid - v0, 0);
    chk("gl_ferr",  n_ferr - f0, 0);

    // Reset in the middle of bit 4
    rx = 1'b0;
    repeat (BD) @(negedge a);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BD) @(negedge a);
    end
    rx = 1'b1;
    repeat (BD / 2) @(negedge a);
    v0 = n_valid;
    b = 1'b1;
    @(negedge a);
    chk("mr_data",  data, 8'h00);
    chk("mr_valid", data_valid, 1'b0);
    chk("mr_ferr",  frame_err, 1'b0);
    chk("mr_crc",   crc, 8'h00);
    chk("mr_zero",  crc_zero, 1'b1);
    chk("mr_busy",  busy, 1'b0);
    repeat (2) @(negedge a);
    b = 1'b0;
    m_crc = 8'h00;
    repeat (2 * BD) @(negedge a);
    chk("mr_no_pulse", n_valid - v0, 0);
    send_good(8'h5A, "mr5a");

    // Random bytes with random idle gaps (including none)
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      send_good(rb, "rnd");
      repeat ($urandom_range(0, 20)) @(negedge a);
    end
    // Close the block with its own CRC byte
    send_good(m_crc, "rnd_tail");
    chk("rnd_tail_zero", crc_zero, 1'b1);
    chk("rnd_ferr", n_ferr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
